// File: rtl/truth_table_scanner_pkg.sv
// Shared definitions for the truth-table scanner: FSM state encoding and table width helpers.
package truth_table_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        FINISH = 2'd2
    } scan_state_t;

    localparam int N_IN_DEFAULT = 3;
    localparam int TT_W_DEFAULT = 2 ** N_IN_DEFAULT;

    function automatic int tt_width(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Scan bus between the scanner (master) and its client / logic under scan (slave).
// The checker signals exist only when SCAN_CHECK_EN is defined.
interface truth_table_scanner_if #(
    parameter int N_IN = 3
);
    import truth_table_scanner_pkg::*;

    localparam int TT_W = tt_width(N_IN);

    logic                start;
    logic [N_IN-1:0]     x;
    logic                y;
    logic                busy;
    logic                done;
    logic [TT_W-1:0]     table_out;
    logic [N_IN:0]       ones_count;
`ifdef SCAN_CHECK_EN
    logic [TT_W-1:0]     expected;
    logic                mismatch;
    logic [N_IN-1:0]     err_idx;
`endif

    modport master (
        input  start,
        input  y,
        output x,
        output busy,
        output done,
        output table_out,
`ifdef SCAN_CHECK_EN
        input  expected,
        output mismatch,
        output err_idx,
`endif
        output ones_count
    );

    modport slave (
        output start,
        output y,
        input  x,
        input  busy,
        input  done,
        input  table_out,
`ifdef SCAN_CHECK_EN
        output expected,
        input  mismatch,
        input  err_idx,
`endif
        input  ones_count
    );

endinterface

// File: rtl/truth_table_scanner_popcount_tt.sv
// Combinational count of the set bits in a truth-table word.
module popcount_tt #(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic [W-1:0]  word,
    output logic [CW-1:0] count
);

    always_comb begin
        count = '0;
        for (int i = 0; i < W; i++) begin
            count = count + CW'(word[i]);
        end
    end

endmodule

// File: rtl/truth_table_scanner.sv
// Self-timed exhaustive scan of an N_IN-input combinational block, capturing its truth table
// and ones count. Define SCAN_CHECK_EN to add the expected-table comparison (mismatch/err_idx).
module truth_table_scanner
    import truth_table_scanner_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    truth_table_scanner_if.master  bus
);

    localparam int TT_W = tt_width(N_IN);
    localparam int CW   = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [N_IN-1:0] IDX_LAST   = '1;
    localparam logic [CW-1:0]   SETTLE_LD  = CW'(SETTLE);

    scan_state_t       state_reg, state_next;
    logic [N_IN-1:0]   idx_reg, idx_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [TT_W-1:0]   table_reg, table_next;
    logic [N_IN:0]     ones_reg, ones_next;
    logic [TT_W-1:0]   table_sampled;
    logic [N_IN:0]     pc_count;
`ifdef SCAN_CHECK_EN
    logic [TT_W-1:0]   exp_reg, exp_next;
    logic              mismatch_reg, mismatch_next;
    logic [N_IN-1:0]   err_idx_reg, err_idx_next;
`endif

    // Table as it will look after the current sample, so the final popcount includes the last bit.
    always_comb begin
        table_sampled          = table_reg;
        table_sampled[idx_reg] = bus.y;
    end

    popcount_tt #(
        .W  (TT_W),
        .CW (N_IN + 1)
    ) u_popcount (
        .word  (table_sampled),
        .count (pc_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            busy_reg     <= 1'b0;
            done_reg     <= 1'b0;
            table_reg    <= '0;
            ones_reg     <= '0;
`ifdef SCAN_CHECK_EN
            exp_reg      <= '0;
            mismatch_reg <= 1'b0;
            err_idx_reg  <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            idx_reg      <= idx_next;
            cnt_reg      <= cnt_next;
            busy_reg     <= busy_next;
            done_reg     <= done_next;
            table_reg    <= table_next;
            ones_reg     <= ones_next;
`ifdef SCAN_CHECK_EN
            exp_reg      <= exp_next;
            mismatch_reg <= mismatch_next;
            err_idx_reg  <= err_idx_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        idx_next      = idx_reg;
        cnt_next      = cnt_reg;
        busy_next     = busy_reg;
        done_next     = 1'b0;
        table_next    = table_reg;
        ones_next     = ones_reg;
`ifdef SCAN_CHECK_EN
        exp_next      = exp_reg;
        mismatch_next = mismatch_reg;
        err_idx_next  = err_idx_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.start) begin
                    table_next    = '0;
                    ones_next     = '0;
                    idx_next      = '0;
                    cnt_next      = SETTLE_LD;
                    busy_next     = 1'b1;
                    state_next    = HOLD;
`ifdef SCAN_CHECK_EN
                    exp_next      = bus.expected;
                    mismatch_next = 1'b0;
                    err_idx_next  = '0;
`endif
                end
            end
            HOLD: begin
                if (cnt_reg != '0) begin
                    cnt_next = cnt_reg - CW'(1);
                end else begin
                    table_next = table_sampled;
`ifdef SCAN_CHECK_EN
                    // Only the first disagreement is recorded.
                    if (!mismatch_reg && (bus.y != exp_reg[idx_reg])) begin
                        mismatch_next = 1'b1;
                        err_idx_next  = idx_reg;
                    end
`endif
                    if (idx_reg == IDX_LAST) begin
                        state_next = FINISH;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                        ones_next  = pc_count;
                    end else begin
                        idx_next = idx_reg + 1'b1;
                        cnt_next = SETTLE_LD;
                    end
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The driven vector is the scan index itself; it holds all ones after a scan.
    assign bus.x          = idx_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.table_out  = table_reg;
    assign bus.ones_count = ones_reg;
`ifdef SCAN_CHECK_EN
    assign bus.mismatch   = mismatch_reg;
    assign bus.err_idx    = err_idx_reg;
`endif

endmodule

// File: tb/tb_truth_table_scanner.sv
// Directed bench for truth_table_scanner: a SETTLE=1 and a SETTLE=0 instance scanning y=(x1&x2)|x3.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst;
    logic start1, start0;
    logic yzero;
    int   sel;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    truth_table_scanner_if #(.N_IN(3)) b1 ();
    truth_table_scanner_if #(.N_IN(3)) b0 ();

    truth_table_scanner #(.N_IN(3), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
    truth_table_scanner #(.N_IN(3), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

    assign b1.start = start1;
    assign b0.start = start0;
    assign b1.y = yzero ? 1'b0 : ((b1.x[2] & b1.x[1]) | b1.x[0]);
    assign b0.y = yzero ? 1'b0 : ((b0.x[2] & b0.x[1]) | b0.x[0]);

`ifdef SCAN_CHECK_EN
    logic [7:0] exp1;
    assign b1.expected = exp1;
    assign b0.expected = 8'hEA;
`endif

    logic [2:0] m_x;
    logic       m_busy, m_done;
    logic [7:0] m_tt;
    logic [3:0] m_cnt;
    assign m_x    = (sel == 0) ? b0.x          : b1.x;
    assign m_busy = (sel == 0) ? b0.busy       : b1.busy;
    assign m_done = (sel == 0) ? b0.done       : b1.done;
    assign m_tt   = (sel == 0) ? b0.table_out  : b1.table_out;
    assign m_cnt  = (sel == 0) ? b0.ones_count : b1.ones_count;

    task automatic set_start(input logic v);
        if (sel == 0) start0 = v; else start1 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One scan on the selected instance; checks per-cycle x, done timing and results.
    task automatic run_scan(input string name, input int settle, input logic [7:0] exp_tt,
                            input logic [3:0] exp_cnt, input bit mid_start);
        int  k;
        bit  got;
        int  span;
        logic [2:0] exp_x;
        span = 8 * (settle + 1);
        set_start(1'b1);
        tick();
        set_start(1'b0);
        total++;
        if (m_busy !== 1'b1) begin bad++; $display("FAIL %s busy_rise: got %b want 1", name, m_busy); end
        k = 0; got = 0;
        while (k < 200 && !got) begin
            if (k < span) begin
                exp_x = 3'(k / (settle + 1));
                total++;
                if (m_x !== exp_x) begin bad++; $display("FAIL %s x_step k=%0d: got %0d want %0d", name, k, m_x, exp_x); end
            end
            if (mid_start && k == 2) set_start(1'b1);
            if (mid_start && k == 4) set_start(1'b0);
            tick();
            k++;
            if (m_done === 1'b1) got = 1;
        end
        total++;
        if (!got || k != span) begin bad++; $display("FAIL %s done_time: got %0d want %0d", name, k, span); end
        total++;
        if (m_busy !== 1'b0) begin bad++; $display("FAIL %s busy_fall: got %b want 0", name, m_busy); end
        total++;
        if (m_tt !== exp_tt) begin bad++; $display("FAIL %s table_out: got %h want %h", name, m_tt, exp_tt); end
        total++;
        if (m_cnt !== exp_cnt) begin bad++; $display("FAIL %s ones_count: got %0d want %0d", name, m_cnt, exp_cnt); end
        tick();
        total++;
        if (m_done !== 1'b0) begin bad++; $display("FAIL %s done_width: got %b want 0", name, m_done); end
        total++;
        if (m_x !== 3'd7 || m_tt !== exp_tt || m_busy !== 1'b0) begin
            bad++; $display("FAIL %s hold_after: got x=%0d tt=%h busy=%b want x=7 tt=%h busy=0", name, m_x, m_tt, m_busy, exp_tt);
        end
        $display("scan %s: table_out=%h ones_count=%0d done_at=%0d", name, m_tt, m_cnt, k);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({b1.x, b1.busy, b1.done, b1.table_out, b1.ones_count} !== 17'd0) begin
            bad++; $display("FAIL reset_s1: got x=%0d busy=%b done=%b tt=%h cnt=%0d want all 0", b1.x, b1.busy, b1.done, b1.table_out, b1.ones_count);
        end
        total++;
        if ({b0.x, b0.busy, b0.done, b0.table_out, b0.ones_count} !== 17'd0) begin
            bad++; $display("FAIL reset_s0: got x=%0d busy=%b done=%b tt=%h cnt=%0d want all 0", b0.x, b0.busy, b0.done, b0.table_out, b0.ones_count);
        end
        rst = 1'b0;
        tick();
        $display("reset: outputs checked");
    endtask

    task automatic test_settle1();
        sel = 1;
        run_scan("settle1", 1, 8'hEA, 4'd5, 1'b0);
    endtask

    task automatic test_settle0();
        sel = 0;
        run_scan("settle0_start_ignored", 0, 8'hEA, 4'd5, 1'b1);
        total++;
        if (m_busy !== 1'b0) begin bad++; $display("FAIL settle0 no_requeue: got busy=%b want 0", m_busy); end
    endtask

    task automatic test_mid_reset();
        int k;
        sel = 1;
        set_start(1'b1);
        tick();
        set_start(1'b0);
        k = 0;
        while (m_x !== 3'd4 && k < 50) begin tick(); k++; end
        total++;
        if (m_x !== 3'd4 || k != 8) begin bad++; $display("FAIL mid_reset reach_v4: got x=%0d k=%0d want x=4 k=8", m_x, k); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        if ({m_x, m_busy, m_done, m_tt, m_cnt} !== 17'd0) begin
            bad++; $display("FAIL mid_reset abort: got x=%0d busy=%b done=%b tt=%h cnt=%0d want all 0", m_x, m_busy, m_done, m_tt, m_cnt);
        end
        tick(); tick();
        total++;
        if (m_busy !== 1'b0 || m_done !== 1'b0) begin bad++; $display("FAIL mid_reset stays_idle: got busy=%b done=%b want 0 0", m_busy, m_done); end
        $display("mid_reset: abort checked");
        run_scan("after_reset", 1, 8'hEA, 4'd5, 1'b0);
    endtask

    task automatic test_zero_logic();
        sel = 1;
        yzero = 1'b1;
        run_scan("y_zero", 1, 8'h00, 4'd0, 1'b0);
        yzero = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k, first, second;
        sel = 1;
        first = -1; second = -1;
        set_start(1'b1);
        tick();
        k = 0;
        while (k < 100 && second < 0) begin
            tick();
            k++;
            if (m_done === 1'b1) begin
                if (first < 0) first = k; else second = k;
            end
            if (first >= 0 && k == first + 1) begin
                total++;
                if (m_busy !== 1'b0 || m_done !== 1'b0) begin bad++; $display("FAIL b2b idle_gap: got busy=%b done=%b want 0 0", m_busy, m_done); end
            end
            if (first >= 0 && k == first + 2) begin
                total++;
                if (m_busy !== 1'b1 || m_tt !== 8'h00 || m_x !== 3'd0) begin
                    bad++; $display("FAIL b2b restart_clear: got busy=%b tt=%h x=%0d want 1 00 0", m_busy, m_tt, m_x);
                end
            end
        end
        set_start(1'b0);
        total++;
        if (first != 16 || second != 34) begin bad++; $display("FAIL b2b done_spacing: got %0d,%0d want 16,34", first, second); end
        total++;
        if (m_tt !== 8'hEA || m_cnt !== 4'd5) begin bad++; $display("FAIL b2b result: got %h/%0d want EA/5", m_tt, m_cnt); end
        tick(); tick();
        total++;
        if (m_busy !== 1'b0) begin bad++; $display("FAIL b2b no_third: got busy=%b want 0", m_busy); end
        $display("back_to_back: done at %0d and %0d", first, second);
    endtask

`ifdef SCAN_CHECK_EN
    task automatic test_check();
        sel = 1;
        exp1 = 8'hEB;
        run_scan("check_eb", 1, 8'hEA, 4'd5, 1'b0);
        total++;
        if (b1.mismatch !== 1'b1 || b1.err_idx !== 3'd0) begin
            bad++; $display("FAIL check_eb: got mismatch=%b err_idx=%0d want 1 0", b1.mismatch, b1.err_idx);
        end
        exp1 = 8'h6A;
        run_scan("check_6a", 1, 8'hEA, 4'd5, 1'b0);
        total++;
        if (b1.mismatch !== 1'b1 || b1.err_idx !== 3'd7) begin
            bad++; $display("FAIL check_6a: got mismatch=%b err_idx=%0d want 1 7", b1.mismatch, b1.err_idx);
        end
        exp1 = 8'hEA;
        run_scan("check_ea", 1, 8'hEA, 4'd5, 1'b0);
        total++;
        if (b1.mismatch !== 1'b0) begin bad++; $display("FAIL check_ea: got mismatch=%b want 0", b1.mismatch); end
    endtask
`endif

    initial begin
        rst = 1'b1;
        start1 = 1'b0;
        start0 = 1'b0;
        yzero = 1'b0;
        sel = 1;
`ifdef SCAN_CHECK_EN
        exp1 = 8'hEA;
`endif
        test_reset();
        test_settle1();
        test_settle0();
        test_mid_reset();
        test_zero_logic();
        test_back_to_back();
`ifdef SCAN_CHECK_EN
        test_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
